// File: rtl/mem_port_arbiter.sv
// Two-requester front end for a single memory with separate read and write
// ports. Read and write channels are arbitrated independently, round-robin.
// Read data returns one cycle after the grant, routed to the issuing
// requester. A read and a write to the same address in the same cycle
// return the new write data.
module mem_port_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [AW-1:0]    mem_rdaddress,
  output logic             mem_rden,
  output logic [AW-1:0]    mem_wraddress,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] mem_q
);

  // Round-robin pick between two contenders. last = index granted most
  // recently; on contention the other requester wins. Result is {g1, g0}.
  function automatic logic [1:0] rr_pick(input logic c0, input logic c1,
                                         input logic last);
    logic g0;
    logic g1;
    g0 = c0 && (!c1 || last);
    g1 = c1 && (!c0 || !last);
    return {g1, g0};
  endfunction

  logic             rd_last;
  logic             wr_last;
  logic             rd_g0;
  logic             rd_g1;
  logic             wr_g0;
  logic             wr_g1;
  logic             byp_p1;
  logic [WIDTH-1:0] byp_data_p1;

  // Grant decode; everything is forced idle while reset is held low.
  always_comb begin
    rd_g0 = 1'b0;
    rd_g1 = 1'b0;
    wr_g0 = 1'b0;
    wr_g1 = 1'b0;
    if (reset_n) begin
      {rd_g1, rd_g0} = rr_pick(req0_valid && !req0_we, req1_valid && !req1_we, rd_last);
      {wr_g1, wr_g0} = rr_pick(req0_valid &&  req0_we, req1_valid &&  req1_we, wr_last);
    end
  end

  assign req0_ready    = rd_g0 || wr_g0;
  assign req1_ready    = rd_g1 || wr_g1;
  assign mem_rden      = rd_g0 || rd_g1;
  assign mem_rdaddress = rd_g1 ? req1_addr : req0_addr;
  assign mem_wren      = wr_g0 || wr_g1;
  assign mem_wraddress = wr_g1 ? req1_addr : req0_addr;
  assign mem_data      = wr_g1 ? req1_wdata : req0_wdata;

  // ---- stage p0 -> p1: grant pointers, response valids, bypass flag ----
  // Control state: round-robin pointers, response valids and bypass select.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_last    <= 1'b1;
      wr_last    <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      byp_p1     <= 1'b0;
    end else begin
      if (mem_rden) rd_last <= rd_g1;
      if (mem_wren) wr_last <= wr_g1;
      rsp0_valid <= rd_g0;
      rsp1_valid <= rd_g1;
      byp_p1     <= mem_rden && mem_wren && (mem_rdaddress == mem_wraddress);
    end
  end

  // Capture write data that may have to replace the stale memory read.
  always_ff @(posedge clock) begin
    if (mem_rden && mem_wren) byp_data_p1 <= mem_data;
  end

  // ---- stage p1: response data ----
  assign rsp0_data = byp_p1 ? byp_data_p1 : mem_q;
  assign rsp1_data = byp_p1 ? byp_data_p1 : mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with an attached memory model and a
// transaction-level reference model, plus directed scenarios with literals.
module tb_mem_port_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0]    req0_addr = '0;
  logic [WIDTH-1:0] req0_wdata = '0;
  logic             req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0]    req1_addr = '0;
  logic [WIDTH-1:0] req1_wdata = '0;
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic [AW-1:0]    mem_rdaddress, mem_wraddress;
  logic             mem_rden, mem_wren;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem_q = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden),
    .mem_wraddress(mem_wraddress), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  // Attached memory: registered read returning old contents on collision.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (mem_wren) mem[mem_wraddress] <= mem_data;
    if (mem_rden) mem_q <= mem[mem_rdaddress];
  end

  // Reference model state: what the requesters should observe.
  logic [WIDTH-1:0] shadow [DEPTH];
  int               rd_winner_last = 1;
  int               wr_winner_last = 1;
  bit               pend0 = 1'b0, pend1 = 1'b0;
  logic [WIDTH-1:0] pend_data = '0;
  int               vectors = 0;
  int               miscompares = 0;

  // Winner of a channel: -1 none, the sole contender, or whoever did not win last.
  function automatic int winner(input bit c0, input bit c1, input int last);
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update on each clock edge, from the values the edge sees.
  always @(posedge clock) begin
    int rw, ww;
    if (!reset_n) begin
      pend0 = 1'b0; pend1 = 1'b0;
      rd_winner_last = 1; wr_winner_last = 1;
    end else begin
      rw = winner(req0_valid && !req0_we, req1_valid && !req1_we, rd_winner_last);
      ww = winner(req0_valid && req0_we, req1_valid && req1_we, wr_winner_last);
      if (ww == 0) shadow[req0_addr] = req0_wdata;
      if (ww == 1) shadow[req1_addr] = req1_wdata;
      pend0 = (rw == 0);
      pend1 = (rw == 1);
      if (rw == 0) pend_data = shadow[req0_addr];
      if (rw == 1) pend_data = shadow[req1_addr];
      if (rw >= 0) rd_winner_last = rw;
      if (ww >= 0) wr_winner_last = ww;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    int rw, ww;
    rw = -1; ww = -1;
    if (reset_n) begin
      rw = winner(req0_valid && !req0_we, req1_valid && !req1_we, rd_winner_last);
      ww = winner(req0_valid && req0_we, req1_valid && req1_we, wr_winner_last);
    end
    check("ready0", req0_ready, (rw == 0 || ww == 0));
    check("ready1", req1_ready, (rw == 1 || ww == 1));
    check("rden", mem_rden, rw >= 0);
    check("wren", mem_wren, ww >= 0);
    if (reset_n) check("rdaddress", mem_rdaddress, (rw == 1) ? req1_addr : req0_addr);
    if (ww >= 0) begin
      check("wraddress", mem_wraddress, (ww == 1) ? req1_addr : req0_addr);
      check("wdata", mem_data, (ww == 1) ? req1_wdata : req0_wdata);
    end
    check("rsp0_valid", rsp0_valid, pend0 && reset_n);
    check("rsp1_valid", rsp1_valid, pend1 && reset_n);
    if (pend0 && reset_n) check("rsp0_data", rsp0_data, pend_data);
    if (pend1 && reset_n) check("rsp1_data", rsp1_data, pend_data);
  end

  // One directed cycle: drive after the edge, settle past the compare point.
  task automatic cyc(input bit v0, input bit we0, input int a0, input int d0,
                     input bit v1, input bit we1, input int a1, input int d1);
    @(posedge clock); #1;
    req0_valid = v0; req0_we = we0; req0_addr = AW'(a0); req0_wdata = WIDTH'(d0);
    req1_valid = v1; req1_we = we1; req1_addr = AW'(a1); req1_wdata = WIDTH'(d1);
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bit acc0, acc1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = WIDTH'(i * 3 + 1);
      shadow[i] = WIDTH'(i * 3 + 1);
    end
    @(negedge clock); #1;
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_ready0", req0_ready, 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    // Write then read back the same word.
    cyc(1, 1, 5, 'hA5, 0, 0, 0, 0);
    check("t1_wr_ready0", req0_ready, 1);
    cyc(1, 0, 5, 0, 0, 0, 0, 0);
    check("t1_rd_ready0", req0_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_data", rsp0_data, 'hA5);
    check("t1_rsp1_valid", rsp1_valid, 0);

    // Both reading continuously: alternating grants, requester 0 first.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 1, 0, 1, 0, 2, 0);
      check("t2_ready0", req0_ready, (k % 2) == 0);
      check("t2_ready1", req1_ready, (k % 2) == 1);
      if (k > 0) begin
        check("t2_rsp0_valid", rsp0_valid, (k % 2) == 1);
        check("t2_rsp_data", (k % 2) ? rsp0_data : rsp1_data, (k % 2) ? 4 : 7);
      end
    end

    // Both writing continuously.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 10, 'h11, 1, 1, 11, 'h22);
      check("t3_wren", mem_wren, 1);
      check("t3_ready0", req0_ready, (k % 2) == 0);
      check("t3_wraddress", mem_wraddress, (k % 2) ? 11 : 10);
      check("t3_wdata", mem_data, (k % 2) ? 'h22 : 'h11);
    end

    // Same-address read/write bypass.
    cyc(1, 0, 9, 0, 1, 1, 9, 'h3C);
    check("t4_ready0", req0_ready, 1);
    check("t4_ready1", req1_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_rsp0_valid", rsp0_valid, 1);
    check("t4_rsp0_data", rsp0_data, 'h3C);

    // Different-address read/write: old data returned.
    cyc(1, 0, 4, 0, 1, 1, 7, 'h55);
    check("t5_both_ready", {req0_ready, req1_ready}, 2'b11);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rsp0_data", rsp0_data, 13);

    // Reset landing on a granted read cancels its response.
    cyc(1, 0, 6, 0, 1, 0, 3, 0);
    check("t6_ready1", req1_ready, 1);
    #2;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock); #1;
    check("t6_rsp0_valid", rsp0_valid, 0);
    check("t6_rsp1_valid", rsp1_valid, 0);
    cyc(1, 0, 1, 0, 1, 0, 2, 0);
    check("t6_first_win0", {req1_ready, req0_ready}, 2'b01);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with stable-while-waiting requesters.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clock); #1;
      if (n % 700 == 350) reset_n = 1'b0;
      else reset_n = 1'b1;
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 9) < 7);
        req0_we    = $urandom_range(0, 1);
        req0_addr  = AW'($urandom_range(0, 7));
        req0_wdata = WIDTH'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 9) < 7);
        req1_we    = $urandom_range(0, 1);
        req1_addr  = AW'($urandom_range(0, 7));
        req1_wdata = WIDTH'($urandom);
      end
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
